// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: duty width/limit, ramp FSM
// encoding, the latched ramp request and the duty clamp helper.
package pwm_pkg;

    localparam int DUTY_W   = 7;
    localparam int DUTY_MAX = 100;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    // Target and step captured when a new request is accepted.
    typedef struct packed {
        logic [DUTY_W-1:0] tgt;
        logic [3:0]        stp;
    } ramp_req_t;

    // Saturate a duty request to the given limit.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                     input logic [DUTY_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Step-interval timer: one-cycle tick every SYS_FREQ*1000*STEP_MS clocks
// while running; clear holds the count at zero so the next run starts a
// fresh interval.
module ramp_tick_gen #(
    parameter int SYS_FREQ = 125,
    parameter int STEP_MS  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int P  = SYS_FREQ * 1000 * STEP_MS;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    logic [CW-1:0] cnt;

    // Count 0..P-1 and wrap; held at zero while cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (clear || cnt == LAST) cnt <= '0;
        else                           cnt <= cnt + CW'(1);
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty source: accepts a target duty over valid/ready and slews
// the registered duty toward it by a fixed step once per step interval.
module pwm_duty_ramp #(
    parameter int SYS_FREQ = 125,
    parameter int STEP_MS  = 10,
    parameter int DUTY_MAX = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic [3:0] step_size,
    output logic [6:0] duty,
    output logic       busy,
    output logic       done
);
    import pwm_pkg::*;

    // One extra bit so duty+step and tgt+step can never wrap.
    localparam int IW = DUTY_W + 1;

    logic [0:0]        state;
    logic [DUTY_W-1:0] duty_q;
    ramp_req_t         req;
    logic              done_q;
    logic              tick;
    logic              accept;
    logic [DUTY_W-1:0] tgt_in;
    logic [3:0]        stp_in;
    logic [IW-1:0]     sum_up;
    logic [IW-1:0]     floor_dn;
    logic [DUTY_W-1:0] nxt;

    assign target_ready = (state == ST_IDLE);
    assign busy         = (state == ST_RAMP);
    assign duty         = duty_q;
    assign done         = done_q;
    assign accept       = target_valid && target_ready;

    // Request conditioning: clamp the target, a zero step means one.
    assign tgt_in = clamp_duty(target, DUTY_W'(DUTY_MAX));
    assign stp_in = (step_size == 4'd0) ? 4'd1 : step_size;

    // The timer only runs in RAMP, so every ramp starts a full interval.
    ramp_tick_gen #(
        .SYS_FREQ (SYS_FREQ),
        .STEP_MS  (STEP_MS)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ST_IDLE),
        .tick    (tick)
    );

    // Next duty on a tick: one step toward tgt, saturating at tgt.
    always_comb begin
        sum_up   = {1'b0, duty_q} + IW'(req.stp);
        floor_dn = {1'b0, req.tgt} + IW'(req.stp);
        nxt      = duty_q;
        if (req.tgt > duty_q)
            nxt = (sum_up > {1'b0, req.tgt}) ? req.tgt : sum_up[DUTY_W-1:0];
        else if ({1'b0, duty_q} < floor_dn)
            nxt = req.tgt;
        else
            nxt = duty_q - DUTY_W'(req.stp);
    end

    // Ramp FSM: latch request in IDLE, step on ticks in RAMP, pulse done
    // for the cycle after the duty lands on target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            duty_q <= '0;
            req    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req.tgt <= tgt_in;
                        req.stp <= stp_in;
                        if (tgt_in == duty_q) done_q <= 1'b1;
                        else                  state  <= ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (tick) begin
                        duty_q <= nxt;
                        if (nxt == req.tgt) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp with P = 1000 clocks. Directed scenarios plus
// random targets, checked against a step-list model of the ramp.
module tb_pwm_duty_ramp;

    localparam int P = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] target;
    logic       target_valid;
    logic       target_ready;
    logic [3:0] step_size;
    logic [6:0] duty;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int mdl_duty = 0;

    always #4 clk = ~clk;

    pwm_duty_ramp #(
        .SYS_FREQ (1),
        .STEP_MS  (1),
        .DUTY_MAX (100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step_size    (step_size),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one request at the current negedge and follow the whole ramp.
    // The model expands the request into the list of duty values it must
    // pass through; each must appear exactly P clocks after the previous.
    task automatic do_target(input int t_raw, input int s_raw, input bit noise);
        int t, s, d;
        int q[$];
        t = (t_raw > 100) ? 100 : t_raw;
        s = (s_raw == 0) ? 1 : s_raw;
        d = mdl_duty;
        while (d != t) begin
            if (t > d) d = (d + s > t) ? t : d + s;
            else       d = (d - s < t) ? t : d - s;
            q.push_back(d);
        end
        target       = 7'(t_raw);
        step_size    = 4'(s_raw);
        target_valid = 1'b1;
        @(negedge clk);
        if (noise) target = 7'd0;
        else       target_valid = 1'b0;
        if (q.size() == 0) begin
            target_valid = 1'b0;
            chk("eq_done",  done, 1);
            chk("eq_busy",  busy, 0);
            chk("eq_ready", target_ready, 1);
            chk("eq_duty",  duty, mdl_duty);
            @(negedge clk);
            chk("eq_done_clr", done, 0);
            chk("eq_duty_hold", duty, mdl_duty);
            return;
        end
        chk("acc_ready", target_ready, 0);
        chk("acc_busy",  busy, 1);
        chk("acc_done",  done, 0);
        foreach (q[i]) begin
            if (noise && i == q.size() - 1) target_valid = 1'b0;
            repeat (P - 1) @(negedge clk);
            chk("pre_tick_duty", duty, mdl_duty);
            chk("pre_tick_busy", busy, 1);
            @(negedge clk);
            mdl_duty = q[i];
            chk("tick_duty", duty, mdl_duty);
            chk("duty_le_max", 32'(duty <= 7'd100), 1);
            if (i < q.size() - 1) begin
                chk("mid_done", done, 0);
            end else begin
                chk("arr_done",  done, 1);
                chk("arr_busy",  busy, 0);
                chk("arr_ready", target_ready, 1);
            end
        end
    endtask

    initial begin
        int t, s, n, tries, mid_exp;
        reset_n      = 1'b0;
        target       = '0;
        target_valid = 1'b0;
        step_size    = '0;
        repeat (3) @(negedge clk);
        chk("rst_duty",  duty, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ready", target_ready, 1);
        chk("rst_done",  done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_duty", duty, 0);

        do_target(50, 10, 0);   // 10,20,30,40,50
        do_target(50, 7, 0);    // already there
        do_target(3, 15, 0);    // 35,20,5,3
        do_target(80, 15, 1);   // valid noise during ramp must be ignored
        do_target(120, 0, 0);   // clamp to 100, step 1

        // random requests, bounded to short ramps
        for (int r = 0; r < 4; r++) begin
            tries = 0;
            do begin
                t = $urandom_range(0, 127);
                s = $urandom_range(0, 15);
                n = (((t > 100) ? 100 : t) - mdl_duty);
                if (n < 0) n = -n;
                n = (n + ((s == 0) ? 1 : s) - 1) / ((s == 0) ? 1 : s);
                tries++;
            end while (n > 5 && tries < 1000);
            if (n > 5) begin
                t = mdl_duty;
                s = 3;
            end
            do_target(t, s, 0);
        end

        // asynchronous reset in the middle of a ramp
        t = (mdl_duty < 50) ? 100 : 0;
        mid_exp = (t > mdl_duty) ? mdl_duty + 20 : mdl_duty - 20;
        target       = 7'(t);
        step_size    = 4'd10;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
        repeat (2 * P + 300) @(negedge clk);
        chk("abort_mid_duty", duty, mid_exp);
        chk("abort_mid_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_duty",  duty, 0);
        chk("abort_busy",  busy, 0);
        chk("abort_ready", target_ready, 1);
        chk("abort_done",  done, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        mdl_duty = 0;
        @(negedge clk);
        do_target(30, 10, 0);   // tick phase must restart from zero

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
